// File: rtl/uart_tx_fifo_if.sv
// Handshake bundle between user logic, the TX FIFO and the UART driver.
// slave: FIFO side (write in, tx out, status out); master: user/driver side.
interface uart_tx_fifo_if #(
  parameter int P_DATA_WIDTH = 8,
  parameter int P_ADDR_WIDTH = 4
);
  logic [P_DATA_WIDTH-1:0] i_wr_data;
  logic                    i_wr_en;
  logic                    o_full;
  logic                    o_almost_full;
  logic [P_DATA_WIDTH-1:0] o_tx_data;
  logic                    o_tx_valid;
  logic                    i_tx_ready;
  logic [P_ADDR_WIDTH:0]   o_count;
  logic                    o_overflow;
  logic                    i_clr_overflow;

  modport slave (
    input  i_wr_data, i_wr_en, i_tx_ready, i_clr_overflow,
    output o_full, o_almost_full, o_tx_data, o_tx_valid,
    output o_count, o_overflow
  );

  modport master (
    output i_wr_data, i_wr_en, i_tx_ready, i_clr_overflow,
    input  o_full, o_almost_full, o_tx_data, o_tx_valid,
    input  o_count, o_overflow
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// FWFT byte buffer feeding the UART driver's transmit user port.
// Ports: clock, reset (sync, active-high), bus (uart_tx_fifo_if.slave).
module uart_tx_fifo #(
  parameter int P_DATA_WIDTH  = 8,
  parameter int P_ADDR_WIDTH  = 4,
  parameter int P_ALMOST_FULL = 14
) (
  input  logic            clock,
  input  logic            reset,
  uart_tx_fifo_if.slave   bus
);
  localparam int DEPTH = 1 << P_ADDR_WIDTH;
  localparam logic [P_ADDR_WIDTH:0] DEPTH_C =
    (P_ADDR_WIDTH+1)'(DEPTH);
  localparam logic [P_ADDR_WIDTH:0] AF_C =
    (P_ADDR_WIDTH+1)'(P_ALMOST_FULL);

  logic [P_DATA_WIDTH-1:0] mem [DEPTH];
  logic [P_ADDR_WIDTH-1:0] wr_ptr;
  logic [P_ADDR_WIDTH-1:0] rd_ptr;
  logic [P_ADDR_WIDTH:0]   count;
  logic [P_ADDR_WIDTH:0]   count_nxt;
  logic                    full;
  logic                    almost_full;
  logic                    valid;
  logic                    overflow;
  logic                    push;
  logic                    pop;

  // A write is refused while full even if a pop frees a slot this cycle.
  assign push = bus.i_wr_en & ~full;
  assign pop  = valid & bus.i_tx_ready;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      valid       <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count       <= count_nxt;
      full        <= (count_nxt == DEPTH_C);
      almost_full <= (count_nxt >= AF_C);
      valid       <= (count_nxt != '0);
      // Set wins over a same-cycle clear.
      if (bus.i_wr_en & full)
        overflow <= 1'b1;
      else if (bus.i_clr_overflow)
        overflow <= 1'b0;
    end
  end

  // Storage is not reset; writes are blocked during reset.
  always_ff @(posedge clock) begin
    if (push & ~reset)
      mem[wr_ptr] <= bus.i_wr_data;
  end

  assign bus.o_full        = full;
  assign bus.o_almost_full = almost_full;
  assign bus.o_tx_valid    = valid;
  assign bus.o_count       = count;
  assign bus.o_overflow    = overflow;
  assign bus.o_tx_data     = valid ? mem[rd_ptr] : '0;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: queue model plus literal checks.
// Ports: none (top-level testbench).
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  uart_tx_fifo_if #(.P_DATA_WIDTH(8), .P_ADDR_WIDTH(4)) bus ();

  uart_tx_fifo #(
    .P_DATA_WIDTH(8),
    .P_ADDR_WIDTH(4),
    .P_ALMOST_FULL(14)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model: a plain queue of accepted bytes plus the sticky flag.
  logic [7:0] q[$];
  bit ovf_m = 1'b0;
  bit armed = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock) begin
    if (reset) begin
      q.delete();
      ovf_m = 1'b0;
      armed = 1'b1;
    end else if (armed) begin
      bit was_full;
      bit do_pop;
      was_full = (q.size() == DEPTH);
      do_pop   = (q.size() != 0) && bus.i_tx_ready;
      if (bus.i_wr_en && was_full) ovf_m = 1'b1;
      else if (bus.i_clr_overflow)  ovf_m = 1'b0;
      if (do_pop) void'(q.pop_front());
      if (bus.i_wr_en && !was_full) q.push_back(bus.i_wr_data);
    end
  end

  always @(negedge clock) begin
    if (armed) begin
      chk("count", 32'(bus.o_count), 32'(q.size()));
      chk("valid", 32'(bus.o_tx_valid), 32'(q.size() != 0));
      chk("data", 32'(bus.o_tx_data),
          q.size() != 0 ? 32'(q[0]) : 32'd0);
      chk("full", 32'(bus.o_full), 32'(q.size() == DEPTH));
      chk("afull", 32'(bus.o_almost_full), 32'(q.size() >= 14));
      chk("ovf", 32'(bus.o_overflow), 32'(ovf_m));
    end
  end

  task automatic drive(input bit we, input logic [7:0] d,
                       input bit rdy, input bit clr = 1'b0);
    @(negedge clock);
    bus.i_wr_en        = we;
    bus.i_wr_data      = d;
    bus.i_tx_ready     = rdy;
    bus.i_clr_overflow = clr;
  endtask

  initial begin
    bus.i_wr_en        = 1'b0;
    bus.i_wr_data      = 8'h00;
    bus.i_tx_ready     = 1'b0;
    bus.i_clr_overflow = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_count", 32'(bus.o_count), 32'd0);
    chk("rst_data", 32'(bus.o_tx_data), 32'd0);
    reset = 1'b0;

    // Three writes, then back-to-back drain.
    drive(1, 8'h41, 0);
    drive(1, 8'h42, 0);
    drive(1, 8'h43, 0);
    drive(0, 8'h00, 0);
    chk("t1_count", 32'(bus.o_count), 32'd3);
    chk("t1_head", 32'(bus.o_tx_data), 32'h41);
    drive(0, 8'h00, 1);
    chk("t1_pop0", 32'(bus.o_tx_data), 32'h41);
    drive(0, 8'h00, 1);
    chk("t1_pop1", 32'(bus.o_tx_data), 32'h42);
    drive(0, 8'h00, 1);
    chk("t1_pop2", 32'(bus.o_tx_data), 32'h43);
    drive(0, 8'h00, 0);
    chk("t1_empty_v", 32'(bus.o_tx_valid), 32'd0);
    chk("t1_empty_d", 32'(bus.o_tx_data), 32'd0);

    // Fill to 16, probing the almost-full and full thresholds.
    for (int i = 0; i < 16; i++) begin
      drive(1, 8'(i), 0);
      if (i == 13) chk("t2_af13", 32'(bus.o_almost_full), 32'd0);
      if (i == 14) chk("t2_af14", 32'(bus.o_almost_full), 32'd1);
      if (i == 15) chk("t2_full15", 32'(bus.o_full), 32'd0);
    end
    drive(1, 8'hFF, 0);
    chk("t2_full16", 32'(bus.o_full), 32'd1);
    drive(0, 8'h00, 0);
    chk("t2_ovf", 32'(bus.o_overflow), 32'd1);
    chk("t2_count", 32'(bus.o_count), 32'd16);

    // Clear alone, then set and clear together, then clear alone.
    drive(0, 8'h00, 0, 1);
    drive(1, 8'hEE, 0, 1);
    chk("t5_clr", 32'(bus.o_overflow), 32'd0);
    drive(0, 8'h00, 0, 1);
    chk("t5_setwins", 32'(bus.o_overflow), 32'd1);
    drive(0, 8'h00, 0);
    chk("t5_clr2", 32'(bus.o_overflow), 32'd0);

    // Full with a simultaneous pop: write dropped, pop proceeds.
    drive(1, 8'hAA, 1);
    drive(0, 8'h00, 0);
    chk("t3_ovf", 32'(bus.o_overflow), 32'd1);
    chk("t3_count", 32'(bus.o_count), 32'd15);
    chk("t3_head", 32'(bus.o_tx_data), 32'h01);
    repeat (15) drive(0, 8'h00, 1);
    drive(0, 8'h00, 0, 1);
    chk("t3_drained", 32'(bus.o_count), 32'd0);

    // Steady state at five entries with push+pop each cycle.
    for (int i = 0; i < 5; i++) drive(1, 8'h60 + 8'(i), 0);
    for (int i = 0; i < 40; i++) drive(1, 8'h80 + 8'(i), 1);
    drive(0, 8'h00, 0);
    chk("t4_count", 32'(bus.o_count), 32'd5);
    chk("t4_head", 32'(bus.o_tx_data), 32'h80 + 32'd35);
    repeat (5) drive(0, 8'h00, 1);

    // Reset mid-operation with a pop and a write pending.
    for (int i = 0; i < 8; i++) drive(1, 8'hC0 + 8'(i), 0);
    drive(1, 8'h99, 1);
    reset = 1'b1;
    drive(0, 8'h00, 0);
    reset = 1'b0;
    chk("t6_count", 32'(bus.o_count), 32'd0);
    chk("t6_valid", 32'(bus.o_tx_valid), 32'd0);
    chk("t6_full", 32'(bus.o_full), 32'd0);
    chk("t6_ovf", 32'(bus.o_overflow), 32'd0);
    drive(1, 8'h5A, 0);
    drive(0, 8'h00, 0);
    chk("t6_data", 32'(bus.o_tx_data), 32'h5A);
    chk("t6_cnt1", 32'(bus.o_count), 32'd1);
    drive(0, 8'h00, 1);
    repeat (2) drive(0, 8'h00, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
